// File: rtl/latch_response_checker.sv
// Response checker for SR / gated SR / D latch DUTs: a golden latch model judges every
// sampled response, and the checker counts checks, errors and forbidden inputs over one run.
module latch_response_checker #(
    parameter int CNT_W  = 8,
    parameter bit STRICT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic             sample,
    input  logic             s,
    input  logic             r,
    input  logic             en,
    input  logic             d,
    input  logic             q,
    input  logic             q_bar,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] checks_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_SR   = 2'd0;
    localparam logic [1:0]       MODE_D    = 2'd2;
    localparam logic [1:0]       MODE_RSVD = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic             r_known;
    logic             r_exp;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_checks;
    logic [CNT_W-1:0] r_errs;
    logic [CNT_W-1:0] r_illegal;

    logic w_run_sample;
    logic w_act;
    logic w_is_d;
    logic w_drive;
    logic w_illegal;
    logic w_exp_nxt;
    logic w_exp_use;
    logic w_known_nxt;
    logic w_pair_bad;
    logic w_check;
    logic w_fail;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] res;
        res = v;
        if (inc && (v != CNT_MAX))
            res = v + CNT_ONE;
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // start has priority over stop in every state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (start)
                    w_state_nxt = ST_RUN;
                else if (stop)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (r_errs == '0) && (r_checks != '0);
                if (start)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Golden latch model: a sample on a restart edge belongs to neither run and is dropped.
    always_comb begin
        w_run_sample = (r_state == ST_RUN) && sample && !start && (r_mode != MODE_RSVD);
        w_is_d       = (r_mode == MODE_D);
        w_act        = (r_mode == MODE_SR) || en;
        w_illegal    = w_run_sample && !w_is_d && w_act && s && r;
        w_drive      = w_run_sample && w_act && (w_is_d || (s != r));
        w_exp_nxt    = w_is_d ? d : s;
        w_exp_use    = w_drive ? w_exp_nxt : r_exp;

        w_known_nxt = r_known;
        if (w_illegal)
            w_known_nxt = 1'b0;
        else if (w_drive)
            w_known_nxt = 1'b1;

        w_pair_bad = (q_bar == q);
        w_check    = w_run_sample && !w_illegal && (w_known_nxt || (STRICT && w_pair_bad));
        w_fail     = 1'b0;
        if (w_check)
            w_fail = w_known_nxt ? ((q != w_exp_use) || w_pair_bad) : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= MODE_SR;
            r_known     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_checks    <= '0;
            r_errs      <= '0;
            r_illegal   <= '0;
        end else begin
            r_err_pulse <= w_fail;
            if (start) begin
                r_mode   <= mode;
                r_known  <= 1'b0;
                r_checks <= '0;
                r_errs   <= '0;
                r_illegal <= '0;
            end else begin
                r_known   <= w_known_nxt;
                r_checks  <= sat_inc(r_checks, w_check);
                r_errs    <= sat_inc(r_errs, w_fail);
                r_illegal <= sat_inc(r_illegal, w_illegal);
            end
        end
    end

    // Expected level is only meaningful while known=1, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_drive)
            r_exp <= w_exp_nxt;
    end

    assign err_pulse   = r_err_pulse;
    assign checks_cnt  = r_checks;
    assign err_cnt     = r_errs;
    assign illegal_cnt = r_illegal;

endmodule

// File: tb/tb_latch_response_checker.sv
// Bench for latch_response_checker: two instances (CNT_W=8/STRICT=1 and CNT_W=2/STRICT=0)
// share one stimulus stream and are compared against a per-instance behavioural model.
module tb_latch_response_checker;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic start = 0, stop = 0, sample = 0;
    logic s = 0, r = 0, en = 0, d = 0, q = 0, q_bar = 1;

    logic a_busy, a_done, a_pass, a_pulse;
    logic [7:0] a_chk, a_err, a_ill;
    logic b_busy, b_done, b_pass, b_pulse;
    logic [1:0] b_chk, b_err, b_ill;

    int errors = 0;
    int checks = 0;

    latch_response_checker #(.CNT_W(8), .STRICT(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .stop(stop),
        .sample(sample), .s(s), .r(r), .en(en), .d(d), .q(q), .q_bar(q_bar),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_pulse(a_pulse),
        .checks_cnt(a_chk), .err_cnt(a_err), .illegal_cnt(a_ill));

    latch_response_checker #(.CNT_W(2), .STRICT(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .stop(stop),
        .sample(sample), .s(s), .r(r), .en(en), .d(d), .q(q), .q_bar(q_bar),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_pulse(b_pulse),
        .checks_cnt(b_chk), .err_cnt(b_err), .illegal_cnt(b_ill));

    always #5 clk = ~clk;

    logic [27:0] obs_a, obs_b;
    assign obs_a = {a_busy, a_done, a_pass, a_pulse, a_chk, a_err, a_ill};
    assign obs_b = {b_busy, b_done, b_pass, b_pulse, 6'b0, b_chk, 6'b0, b_err, 6'b0, b_ill};

    // Behavioural model, index 0 = dut_a, 1 = dut_b.
    bit m_run[2], m_done[2], m_known[2], m_exp[2], m_pulse[2];
    int m_mode[2], m_chk[2], m_err[2], m_ill[2];
    bit m_strict[2] = '{1'b1, 1'b0};
    int m_max[2] = '{255, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_done[k] = 0; m_known[k] = 0; m_pulse[k] = 0;
            m_mode[k] = 0; m_chk[k] = 0; m_err[k] = 0; m_ill[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit act, illegal, counted, failed;
        m_pulse[k] = 0;
        if (start) begin
            m_run[k] = 1; m_done[k] = 0; m_mode[k] = int'(mode); m_known[k] = 0;
            m_chk[k] = 0; m_err[k] = 0; m_ill[k] = 0;
        end else if (m_run[k]) begin
            if (sample && m_mode[k] != 3) begin
                act = (m_mode[k] == 0) || en;
                illegal = 0;
                if (m_mode[k] == 2) begin
                    if (act) begin m_exp[k] = d; m_known[k] = 1; end
                end else if (act && s && r) begin
                    illegal = 1; m_known[k] = 0;
                    if (m_ill[k] < m_max[k]) m_ill[k]++;
                end else if (act && s != r) begin
                    m_exp[k] = s; m_known[k] = 1;
                end
                counted = 0; failed = 0;
                if (!illegal) begin
                    if (m_known[k]) begin
                        counted = 1; failed = (q != m_exp[k]) || (q_bar == q);
                    end else if (m_strict[k] && q_bar == q) begin
                        counted = 1; failed = 1;
                    end
                end
                if (counted && m_chk[k] < m_max[k]) m_chk[k]++;
                if (failed) begin
                    m_pulse[k] = 1;
                    if (m_err[k] < m_max[k]) m_err[k]++;
                end
            end
            if (stop) begin m_run[k] = 0; m_done[k] = 1; end
        end
    endtask

    function automatic logic [27:0] mvec(input int k);
        logic p;
        p = m_done[k] && m_err[k] == 0 && m_chk[k] != 0;
        return {m_run[k], m_done[k], p, m_pulse[k], 8'(m_chk[k]), 8'(m_err[k]), 8'(m_ill[k])};
    endfunction

    task automatic apply(input bit st, sp, smp, s_i, r_i, en_i, d_i, q_i, qb_i);
        start = st; stop = sp; sample = smp;
        s = s_i; r = r_i; en = en_i; d = d_i; q = q_i; q_bar = qb_i;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        start = 0; stop = 0; sample = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs_a !== 28'd0) begin errors++; $display("FAIL reset_a got=%h want=0", obs_a); end
        checks++;
        if (obs_b !== 28'd0) begin errors++; $display("FAIL reset_b got=%h want=0", obs_b); end
        #10 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_d_mode();
        mode = 2'd2;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL d_busy got=%b want=1", a_busy); end
        apply(0, 0, 1, 0, 0, 1, 1, 1, 0);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 1);
        apply(0, 0, 1, 0, 0, 1, 1, 1, 0);
        apply(0, 0, 1, 0, 0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({a_busy, a_done, a_pass, a_chk, a_err} !== {3'b011, 8'd4, 8'd0}) begin
            errors++; $display("FAIL d_run got=%b%b%b chk=%0d err=%0d want=011 chk=4 err=0",
                               a_busy, a_done, a_pass, a_chk, a_err);
        end
        checks++;
        if (obs_b !== mvec(1)) begin errors++; $display("FAIL d_b got=%h want=%h", obs_b, mvec(1)); end
    endtask

    task automatic test_sr_mode();
        mode = 2'd0;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (a_chk !== 8'd0) begin errors++; $display("FAIL sr_unknown chk=%0d want=0", a_chk); end
        apply(0, 0, 1, 0, 1, 0, 0, 0, 1);
        apply(0, 0, 1, 1, 0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({a_chk, a_err, a_pass} !== {8'd2, 8'd0, 1'b1}) begin
            errors++; $display("FAIL sr_run chk=%0d err=%0d pass=%b want chk=2 err=0 pass=1",
                               a_chk, a_err, a_pass);
        end
    endtask

    task automatic test_gated_sr();
        mode = 2'd1;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 1, 1, 0, 0, 0, 0, 1);
        checks++;
        if ({a_err, a_pulse} !== {8'd0, 1'b0}) begin
            errors++; $display("FAIL gsr_hold err=%0d pulse=%b want err=0 pulse=0", a_err, a_pulse);
        end
        apply(0, 0, 1, 1, 0, 1, 0, 0, 1);
        checks++;
        if ({a_err, a_pulse} !== {8'd1, 1'b1}) begin
            errors++; $display("FAIL gsr_err err=%0d pulse=%b want err=1 pulse=1", a_err, a_pulse);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (a_pulse !== 1'b0) begin errors++; $display("FAIL gsr_pulse_len got=%b want=0", a_pulse); end
        apply(0, 1, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({a_done, a_pass} !== 2'b10) begin
            errors++; $display("FAIL gsr_pass done=%b pass=%b want done=1 pass=0", a_done, a_pass);
        end
        checks++;
        if (obs_b !== mvec(1)) begin errors++; $display("FAIL gsr_b got=%h want=%h", obs_b, mvec(1)); end
    endtask

    task automatic test_illegal_strict();
        mode = 2'd0;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 1, 1, 1, 0, 0, 0, 0);
        checks++;
        if ({a_ill, a_err, a_chk} !== {8'd1, 8'd0, 8'd0}) begin
            errors++; $display("FAIL illegal ill=%0d err=%0d chk=%0d want 1/0/0", a_ill, a_err, a_chk);
        end
        apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({a_err, a_chk} !== {8'd1, 8'd1}) begin
            errors++; $display("FAIL strict_a err=%0d chk=%0d want 1/1", a_err, a_chk);
        end
        checks++;
        if ({b_err, b_chk, b_ill} !== {2'd0, 2'd0, 2'd1}) begin
            errors++; $display("FAIL strict_b err=%0d chk=%0d ill=%0d want 0/0/1", b_err, b_chk, b_ill);
        end
        apply(0, 0, 1, 0, 0, 0, 0, 1, 0);
        checks++;
        if (a_chk !== 8'd1) begin errors++; $display("FAIL hold_unknown chk=%0d want=1", a_chk); end
    endtask

    task automatic test_saturation();
        mode = 2'd2;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            apply(0, 0, 1, 0, 0, 1, 1, 0, 1);
        checks++;
        if ({b_err, b_chk} !== {2'd3, 2'd3}) begin
            errors++; $display("FAIL sat_b err=%0d chk=%0d want 3/3", b_err, b_chk);
        end
        checks++;
        if (a_err !== 8'd5) begin errors++; $display("FAIL sat_a err=%0d want=5", a_err); end
        apply(0, 1, 0, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({b_busy, b_done, b_chk, b_err, b_ill} !== {2'b10, 6'd0}) begin
            errors++; $display("FAIL restart_b got=%h want busy=1 rest=0", obs_b);
        end
        checks++;
        if (obs_a !== {4'b1000, 24'd0}) begin
            errors++; $display("FAIL restart_a got=%h want=%h", obs_a, {4'b1000, 24'd0});
        end
    endtask

    task automatic test_reset_and_simultaneous();
        mode = 2'd2;
        apply(0, 0, 1, 0, 0, 1, 1, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_a !== 28'd0) begin errors++; $display("FAIL async_reset got=%h want=0", obs_a); end
        #3 reset_n = 1'b1;
        apply(1, 1, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({a_busy, a_done} !== 2'b10) begin
            errors++; $display("FAIL start_beats_stop busy=%b done=%b want 1/0", a_busy, a_done);
        end
        apply(0, 1, 1, 0, 0, 1, 1, 1, 0);
        checks++;
        if ({a_done, a_chk, a_pass} !== {1'b1, 8'd1, 1'b1}) begin
            errors++; $display("FAIL stop_with_sample done=%b chk=%0d pass=%b want 1/1/1",
                               a_done, a_chk, a_pass);
        end
        apply(0, 0, 1, 0, 0, 1, 1, 0, 0);
        checks++;
        if ({a_chk, a_err} !== {8'd1, 8'd0}) begin
            errors++; $display("FAIL sample_in_done chk=%0d err=%0d want 1/0", a_chk, a_err);
        end
    endtask

    task automatic test_random();
        bit qv;
        for (int i = 0; i < 600; i++) begin
            if (!m_run[0] || $urandom_range(0, 29) == 0)
                mode = 2'($urandom_range(0, 3));
            qv = ($urandom_range(0, 3) != 0) ? m_exp[0] : 1'($urandom);
            apply($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  qv, ($urandom_range(0, 5) != 0) ? ~qv : qv);
            checks++;
            if (obs_a !== mvec(0)) begin
                errors++; $display("FAIL rand_a cyc=%0d got=%h want=%h", i, obs_a, mvec(0));
            end
            checks++;
            if (obs_b !== mvec(1)) begin
                errors++; $display("FAIL rand_b cyc=%0d got=%h want=%h", i, obs_b, mvec(1));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_d_mode();
        test_sr_mode();
        test_gated_sr();
        test_illegal_strict();
        test_saturation();
        test_reset_and_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
